reduction_feeder: RTL and testbench

- Upstream stage of the tile reduction accumulator.
- Accepts a stream of tile rows (TILE_SIZE fp16 lanes each) over a valid/ready handshake for a configured reduction pass of N rows.
- Packs rows into bundles of PARALLEL_SIZE, zero-pads the final partial bundle, and issues one bundle per op_valid_o pulse.
- Drives first_o/last_o so the accumulator knows when to load its initial value and when the pass result is final.

---
 rtl/reduction_feeder.sv | 143 ++++++++++++++
 tb/tb_reduction_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_feeder.sv
// Upstream stage of the tile reduction accumulator: packs incoming tile rows into
// zero-padded bundles of PARALLEL_SIZE rows and flags the first and last bundle of a pass.
module reduction_feeder #(
    parameter int WIDTH         = 16,
    parameter int TILE_SIZE     = 129,
    parameter int PARALLEL_SIZE = 3,
    parameter int CNT_W         = 16
) (
    input  logic                                    CLK_i,
    input  logic                                    RST_i,
    input  logic                                    start_i,
    input  logic [CNT_W-1:0]                        cfg_rows_i,
    input  logic                                    row_valid_i,
    output logic                                    row_ready_o,
    input  logic [TILE_SIZE*WIDTH-1:0]              row_data_i,
    output logic                                    op_valid_o,
    output logic [PARALLEL_SIZE*TILE_SIZE*WIDTH-1:0] operand_o,
    output logic                                    first_o,
    output logic                                    last_o,
    output logic                                    busy_o,
    output logic                                    done_o
);

    localparam int ROW_W    = TILE_SIZE * WIDTH;
    localparam int BUNDLE_W = PARALLEL_SIZE * ROW_W;
    localparam int SLOT_W   = $clog2(PARALLEL_SIZE + 1);
    localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(PARALLEL_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                first_q, first_d;
    logic                handshake;
    logic                load_bundle;
    logic [ROW_W-1:0]    staging_q [PARALLEL_SIZE];
    logic [BUNDLE_W-1:0] operand_q;
    logic [BUNDLE_W-1:0] bundle_next;

    assign row_ready_o = (state_q == FILL) && (slot_q < SLOT_FULL) && (rem_q != '0);
    assign handshake   = row_valid_i && row_ready_o;
    assign operand_o   = operand_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        slot_d      = slot_q;
        first_d     = first_q;
        load_bundle = 1'b0;
        op_valid_o  = 1'b0;
        first_o     = 1'b0;
        last_o      = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = cfg_rows_i;
                    slot_d  = '0;
                    first_d = 1'b1;
                    state_d = (cfg_rows_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                busy_o = 1'b1;
                if (handshake) begin
                    slot_d = slot_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if ((slot_d == SLOT_FULL) || (rem_d == '0)) begin
                        state_d     = ISSUE;
                        load_bundle = 1'b1;
                    end
                end
            end
            ISSUE: begin
                busy_o     = 1'b1;
                op_valid_o = 1'b1;
                first_o    = first_q;
                last_o     = (rem_q == '0);
                first_d    = 1'b0;
                slot_d     = '0;
                state_d    = (rem_q == '0) ? DONE : FILL;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bundle as it will look after this cycle's handshake, with unfilled slots padded to +0.0.
    always_comb begin
        bundle_next = '0;
        for (int p = 0; p < PARALLEL_SIZE; p++) begin
            if (handshake && (slot_q == SLOT_W'(p))) begin
                bundle_next[p*ROW_W +: ROW_W] = row_data_i;
            end else if (SLOT_W'(p) < slot_q) begin
                bundle_next[p*ROW_W +: ROW_W] = staging_q[p];
            end
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            slot_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            slot_q  <= slot_d;
            first_q <= first_d;
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            for (int p = 0; p < PARALLEL_SIZE; p++) begin
                staging_q[p] <= '0;
            end
            operand_q <= '0;
        end else begin
            for (int p = 0; p < PARALLEL_SIZE; p++) begin
                if (handshake && (slot_q == SLOT_W'(p))) begin
                    staging_q[p] <= row_data_i;
                end
            end
            if (load_bundle) begin
                operand_q <= bundle_next;
            end
        end
    end

endmodule

// File: tb/tb_reduction_feeder.sv
// Self-checking bench for reduction_feeder: table-driven passes scored against a
// queue of expected bundles, plus hand-written reset-abort and start-ignore sequences.
module tb_reduction_feeder;

    localparam int WIDTH     = 16;
    localparam int TILE_SIZE = 129;
    localparam int P         = 3;
    localparam int CNT_W     = 16;
    localparam int ROW_W     = TILE_SIZE * WIDTH;
    localparam int BUNDLE_W  = P * ROW_W;

    logic                CLK_i = 1'b0;
    logic                RST_i;
    logic                start_i;
    logic [CNT_W-1:0]    cfg_rows_i;
    logic                row_valid_i;
    logic                row_ready_o;
    logic [ROW_W-1:0]    row_data_i;
    logic                op_valid_o;
    logic [BUNDLE_W-1:0] operand_o;
    logic                first_o;
    logic                last_o;
    logic                busy_o;
    logic                done_o;

    reduction_feeder #(
        .WIDTH(WIDTH), .TILE_SIZE(TILE_SIZE), .PARALLEL_SIZE(P), .CNT_W(CNT_W)
    ) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .start_i(start_i), .cfg_rows_i(cfg_rows_i),
        .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_data_i(row_data_i),
        .op_valid_o(op_valid_o), .operand_o(operand_o), .first_o(first_o),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        logic [BUNDLE_W-1:0] data;
        logic                first;
        logic                last;
    } bundle_t;

    typedef struct {
        int         n;
        logic [5:0] vpat;
        int         nb;
    } vec_t;

    bundle_t exp_q[$];
    bundle_t mon_exp;
    vec_t    vecs[7];
    int      checks = 0;
    int      fails = 0;
    int      op_count = 0;
    int      done_count = 0;
    bit      ready_seen = 1'b0;

    function automatic logic [ROW_W-1:0] row_word(input int tag, input int k);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < TILE_SIZE; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'(32'h3C00 + (k << 8) + i) ^ WIDTH'(tag << 12);
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] junk_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < TILE_SIZE; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every issued bundle is matched against the oldest expectation.
    always @(negedge CLK_i) begin
        if (row_ready_o) ready_seen = 1'b1;
        if (done_o) done_count++;
        if (op_valid_o) begin
            op_count++;
            checkOutput("ready_low_in_issue", 32'(row_ready_o), 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_bundle", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("first_o", 32'(first_o), 32'(mon_exp.first));
                checkOutput("last_o", 32'(last_o), 32'(mon_exp.last));
                checks++;
                if (operand_o !== mon_exp.data) begin
                    fails++;
                    for (int l = 0; l < P * TILE_SIZE; l++) begin
                        if (operand_o[l*WIDTH +: WIDTH] !== mon_exp.data[l*WIDTH +: WIDTH]) begin
                            $display("[TB] FAIL operand_o lane %0d: got %h, expected %h",
                                     l, operand_o[l*WIDTH +: WIDTH], mon_exp.data[l*WIDTH +: WIDTH]);
                            break;
                        end
                    end
                end
            end
        end else if (busy_o) begin
            checkOutput("ready_in_fill", 32'(row_ready_o), 32'd1);
        end
    end

    task automatic push_expect(input int tag, input int n);
        bundle_t b;
        int nb;
        nb = (n + P - 1) / P;
        for (int g = 0; g < nb; g++) begin
            b.data = '0;
            for (int p = 0; p < P; p++) begin
                if (g * P + p < n) b.data[p*ROW_W +: ROW_W] = row_word(tag, g * P + p);
            end
            b.first = (g == 0);
            b.last  = (g == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Starts at a negedge, drives the start pulse and leaves at the negedge after it.
    task automatic start_pass(input int n);
        @(negedge CLK_i);
        start_i    = 1'b1;
        cfg_rows_i = CNT_W'(n);
        @(negedge CLK_i);
        start_i    = 1'b0;
        cfg_rows_i = '1;
    endtask

    task automatic feed_rows(input int tag, input int n, input int count, input logic [5:0] vpat, input int poke_k);
        int  k = 0;
        int  j = 0;
        bit  hs;
        bit  expect_issue = 1'b0;
        bit  poked = 1'b0;
        while (k < count && j < 200) begin
            if (j > 0) checkOutput("issue_latency", 32'(op_valid_o), 32'(expect_issue));
            row_valid_i = vpat[j % 6];
            row_data_i  = row_valid_i ? row_word(tag, k) : junk_row();
            if (!poked && k == poke_k) begin
                start_i    = 1'b1;
                cfg_rows_i = CNT_W'(9);
                poked      = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            #1 hs = row_valid_i && row_ready_o;
            @(posedge CLK_i);
            if (hs) k++;
            expect_issue = hs && ((k % P == 0) || (k == n));
            j++;
            @(negedge CLK_i);
        end
        checkOutput("feed_rows_accepted", 32'(k), 32'(count));
        checkOutput("issue_latency", 32'(op_valid_o), 32'(expect_issue));
        row_valid_i = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic applyStimulus(input int tag, input int n, input logic [5:0] vpat, input int poke_k, input int nb);
        int ops0;
        int dones0;
        int cycles = 0;
        ops0       = op_count;
        dones0     = done_count;
        ready_seen = 1'b0;
        push_expect(tag, n);
        start_pass(n);
        feed_rows(tag, n, n, vpat, poke_k);
        while (done_count == dones0 && cycles < 20) begin
            @(negedge CLK_i);
            cycles++;
        end
        if (n == 0) checkOutput("zero_pass_done_latency", 32'(cycles <= 2), 32'd1);
        repeat (3) @(negedge CLK_i);
        checkOutput("bundle_count", 32'(op_count - ops0), 32'(nb));
        checkOutput("done_count", 32'(done_count - dones0), 32'd1);
        checkOutput("ready_seen", 32'(ready_seen), 32'(n != 0));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int ops0;
        int dones0;
        vecs[0] = '{6, 6'b111111, 2};
        vecs[1] = '{4, 6'b111111, 2};
        vecs[2] = '{1, 6'b111111, 1};
        vecs[3] = '{0, 6'b111111, 0};
        vecs[4] = '{3, 6'b101001, 1};
        vecs[5] = '{7, 6'b110110, 3};
        vecs[6] = '{5, 6'b010101, 2};

        RST_i       = 1'b1;
        start_i     = 1'b0;
        cfg_rows_i  = '0;
        row_valid_i = 1'b0;
        row_data_i  = '0;
        #1;
        checkOutput("reset_op_valid", 32'(op_valid_o), 32'd0);
        checkOutput("reset_ready", 32'(row_ready_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_operand_zero", 32'(operand_o != '0), 32'd0);
        repeat (2) @(negedge CLK_i);
        RST_i = 1'b0;

        for (int t = 0; t < 7; t++) begin
            applyStimulus(t + 1, vecs[t].n, vecs[t].vpat, -1, vecs[t].nb);
        end

        // Abort a 6-row pass after 2 rows; reset must clear everything at once.
        ops0   = op_count;
        dones0 = done_count;
        start_pass(6);
        feed_rows(8, 6, 2, 6'b111111, -1);
        #2 RST_i = 1'b1;
        #1;
        checkOutput("abort_op_valid", 32'(op_valid_o), 32'd0);
        checkOutput("abort_ready", 32'(row_ready_o), 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_first_last", 32'({first_o, last_o}), 32'd0);
        checkOutput("abort_operand_zero", 32'(operand_o != '0), 32'd0);
        @(negedge CLK_i);
        RST_i = 1'b0;
        repeat (6) @(negedge CLK_i);
        checkOutput("abort_no_bundle", 32'(op_count - ops0), 32'd0);
        checkOutput("abort_no_done", 32'(done_count - dones0), 32'd0);
        applyStimulus(9, 3, 6'b111111, -1, 1);

        // start_i with a different row count mid-pass must be ignored.
        applyStimulus(10, 3, 6'b111111, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
